// File: rtl/adc_code_averager.sv
// Windowed ADC code averager: accumulates 2^L accepted codes, then holds the average until it is consumed.
// Build option ADC_AVG_ROUND_EN selects saturated round-half-up instead of truncation. Requires L >= 1.
module adc_code_averager #(
  parameter int N = 3,
  parameter int L = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] code_in,
  input  logic         code_valid,
  output logic [N-1:0] avg_out,
  output logic         avg_valid,
  input  logic         avg_ready,
  output logic         clip_flag,
  output logic         drop_flag
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int SW = N + L;
  localparam logic [L-1:0] CNT_LAST = {L{1'b1}};
  localparam logic [N-1:0] CODE_MAX = {N{1'b1}};

  state_t        state_reg, state_next;
  logic [SW-1:0] sum_reg, sum_next;
  logic [L-1:0]  cnt_reg, cnt_next;
  logic          clip_acc_reg, clip_acc_next;
  logic [N-1:0]  avg_reg, avg_next;
  logic          valid_reg, valid_next;
  logic          clip_out_reg, clip_out_next;
  logic          drop_reg, drop_next;

  logic [SW-1:0] sum_add;
  logic          sample_clip;
  logic [N-1:0]  avg_calc;

  // Sum including the sample on the input this cycle; used for the final window total.
  assign sum_add     = sum_reg + SW'(code_in);
  assign sample_clip = (code_in == CODE_MAX) || (code_in == '0);

`ifdef ADC_AVG_ROUND_EN
  localparam logic [SW:0] ROUND_HALF = (SW + 1)'(1 << (L - 1));
  logic [SW:0] sum_round;
  logic [N:0]  avg_wide;

  // One extra bit so adding the half-LSB can never wrap before saturation.
  assign sum_round = {1'b0, sum_add} + ROUND_HALF;
  assign avg_wide  = sum_round[SW:L];
  assign avg_calc  = avg_wide[N] ? CODE_MAX : avg_wide[N-1:0];
`else
  assign avg_calc  = sum_add[SW-1:L];
`endif

  always_comb begin
    state_next    = state_reg;
    sum_next      = sum_reg;
    cnt_next      = cnt_reg;
    clip_acc_next = clip_acc_reg;
    avg_next      = avg_reg;
    valid_next    = valid_reg;
    clip_out_next = clip_out_reg;
    drop_next     = drop_reg;

    case (state_reg)
      ACCUM: begin
        if (code_valid) begin
          sum_next      = sum_add;
          cnt_next      = cnt_reg + 1'b1;
          clip_acc_next = clip_acc_reg | sample_clip;
          if (cnt_reg == CNT_LAST) begin
            state_next    = HOLD;
            avg_next      = avg_calc;
            valid_next    = 1'b1;
            clip_out_next = clip_acc_reg | sample_clip;
            sum_next      = '0;
            clip_acc_next = 1'b0;
          end
        end
      end
      HOLD: begin
        // Samples arriving while a result is pending are lost, even on the release cycle.
        if (code_valid) begin
          drop_next = 1'b1;
        end
        if (avg_ready) begin
          state_next    = ACCUM;
          avg_next      = '0;
          valid_next    = 1'b0;
          clip_out_next = 1'b0;
          sum_next      = '0;
          cnt_next      = '0;
          clip_acc_next = 1'b0;
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ACCUM;
      sum_reg      <= '0;
      cnt_reg      <= '0;
      clip_acc_reg <= 1'b0;
      avg_reg      <= '0;
      valid_reg    <= 1'b0;
      clip_out_reg <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sum_reg      <= sum_next;
      cnt_reg      <= cnt_next;
      clip_acc_reg <= clip_acc_next;
      avg_reg      <= avg_next;
      valid_reg    <= valid_next;
      clip_out_reg <= clip_out_next;
      drop_reg     <= drop_next;
    end
  end

  assign avg_out   = avg_reg;
  assign avg_valid = valid_reg;
  assign clip_flag = clip_out_reg;
  assign drop_flag = drop_reg;

endmodule

// File: tb/tb_adc_code_averager.sv
// Self-checking bench for adc_code_averager: queue-based window model compared every cycle,
// plus hand-computed literal expectations for the directed windows.
module tb_adc_code_averager;

  localparam int N = 3;
  localparam int L = 2;
  localparam int W = 1 << L;
  localparam int CMAX = (1 << N) - 1;

  logic         clk;
  logic         rst;
  logic [N-1:0] code_in;
  logic         code_valid;
  logic [N-1:0] avg_out;
  logic         avg_valid;
  logic         avg_ready;
  logic         clip_flag;
  logic         drop_flag;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

`ifdef ADC_AVG_ROUND_EN
  localparam int E1122 = 2;
  localparam int E7776 = 7;
  localparam int E1234 = 3;
`else
  localparam int E1122 = 1;
  localparam int E7776 = 6;
  localparam int E1234 = 2;
`endif

  adc_code_averager #(.N(N), .L(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .clip_flag  (clip_flag),
    .drop_flag  (drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a queue of accepted codes forms the window.
  int q[$];
  bit m_hold  = 0;
  int m_avg   = 0;
  bit m_clip  = 0;
  bit m_drop  = 0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_hold = 0; m_avg = 0; m_clip = 0; m_drop = 0;
    end else if (m_hold) begin
      if (code_valid) m_drop = 1;
      if (avg_ready) begin
        m_hold = 0; m_avg = 0; m_clip = 0;
      end
    end else if (code_valid) begin
      q.push_back(int'(code_in));
      if (q.size() == W) begin
        int s;
        s = 0;
        m_clip = 0;
        foreach (q[i]) begin
          s += q[i];
          if (q[i] == 0 || q[i] == CMAX) m_clip = 1;
        end
`ifdef ADC_AVG_ROUND_EN
        m_avg = (s + W / 2) / W;
        if (m_avg > CMAX) m_avg = CMAX;
`else
        m_avg = s / W;
`endif
        m_hold = 1;
        q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_avg_valid", int'(avg_valid), int'(m_hold));
      chk("cyc_avg_out",   int'(avg_out),   m_avg);
      chk("cyc_clip_flag", int'(clip_flag), int'(m_clip));
      chk("cyc_drop_flag", int'(drop_flag), int'(m_drop));
    end
  end

  task automatic step(input logic v, input logic [N-1:0] c, input logic r);
    code_valid = v; code_in = c; avg_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic window(input int a, input int b, input int c, input int d, input logic r);
    step(1'b1, N'(a), r);
    step(1'b1, N'(b), r);
    step(1'b1, N'(c), r);
    chk("no_early_valid", int'(avg_valid), 0);
    step(1'b1, N'(d), r);
  endtask

  task automatic release_result();
    step(1'b0, '0, 1'b1);
    chk("released_valid", int'(avg_valid), 0);
  endtask

  initial begin
    rst = 1'b1; code_valid = 1'b0; code_in = '0; avg_ready = 1'b0;
    @(posedge clk); #1;
    started = 1;
    step(1'b0, '0, 1'b0);
    chk("rst_avg_valid", int'(avg_valid), 0);
    chk("rst_avg_out",   int'(avg_out),   0);
    chk("rst_clip",      int'(clip_flag), 0);
    chk("rst_drop",      int'(drop_flag), 0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0);

    window(1, 2, 2, 3, 1'b0);
    $display("window 1,2,2,3 -> avg=%0d clip=%0d", avg_out, clip_flag);
    chk("w1223_valid", int'(avg_valid), 1);
    chk("w1223_avg",   int'(avg_out),   2);
    chk("w1223_clip",  int'(clip_flag), 0);
    release_result();

    // avg_ready held high through accumulation must not disturb the window.
    window(1, 1, 2, 2, 1'b1);
    $display("window 1,1,2,2 -> avg=%0d", avg_out);
    chk("w1122_avg", int'(avg_out), E1122);
    release_result();

    window(7, 7, 7, 6, 1'b0);
    $display("window 7,7,7,6 -> avg=%0d clip=%0d", avg_out, clip_flag);
    chk("w7776_avg",  int'(avg_out),   E7776);
    chk("w7776_clip", int'(clip_flag), 1);
    release_result();

    window(7, 7, 7, 7, 1'b0);
    $display("window 7,7,7,7 -> avg=%0d clip=%0d", avg_out, clip_flag);
    chk("w7777_avg",  int'(avg_out),   7);
    chk("w7777_clip", int'(clip_flag), 1);
    release_result();

    window(1, 2, 3, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, N'(5), 1'b0);
      chk("hold_avg_stable", int'(avg_out), E1234);
      chk("hold_valid",      int'(avg_valid), 1);
    end
    chk("hold_drop", int'(drop_flag), 1);
    step(1'b1, N'(5), 1'b1);
    chk("release_drop_valid", int'(avg_valid), 0);
    window(6, 6, 6, 6, 1'b0);
    $display("window after hold 6,6,6,6 -> avg=%0d drop=%0d", avg_out, drop_flag);
    chk("w6666_avg",  int'(avg_out),   6);
    chk("w6666_clip", int'(clip_flag), 0);
    release_result();

    step(1'b1, N'(3), 1'b0);
    step(1'b1, N'(4), 1'b0);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    chk("midrst_drop",  int'(drop_flag), 0);
    chk("midrst_valid", int'(avg_valid), 0);
    window(0, 0, 0, 1, 1'b0);
    $display("window after reset 0,0,0,1 -> avg=%0d clip=%0d", avg_out, clip_flag);
    chk("w0001_avg",  int'(avg_out),   0);
    chk("w0001_clip", int'(clip_flag), 1);
    release_result();

    for (int i = 0; i < 4; i++) begin
      step(1'b1, N'(4), 1'b0);
      if (i < 3) begin
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("gap_no_valid", int'(avg_valid), 0);
      end
    end
    $display("gapped window 4,4,4,4 -> valid=%0d avg=%0d", avg_valid, avg_out);
    chk("gap_valid", int'(avg_valid), 1);
    chk("gap_avg",   int'(avg_out),   4);
    release_result();

    // Reset while holding discards the pending result.
    window(2, 2, 2, 2, 1'b0);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    chk("hold_rst_valid", int'(avg_valid), 0);
    step(1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
